// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, constants and state encodings for the boot-loaded instruction ROM.
// Also provides the big-endian byte placement helper used by the byte packer.
package inst_rom_loader_pkg;

  localparam int INSTMEMNUMLOG2 = 10;
  localparam int REGBUS         = 32;
  localparam int INSTADDRBUS    = 32;

  localparam logic [REGBUS-1:0] ZEROWORD = 32'h0;

  typedef enum logic [1:0] {
    LOAD_S = 2'b00,
    HOLD_S = 2'b01,
    RUN_S  = 2'b10
  } loader_state_e;

  // Byte 0 of a word lands in the most significant lane.
  function automatic logic [REGBUS-1:0] place_byte(input logic [REGBUS-1:0] word,
                                                   input logic [1:0]        pos,
                                                   input logic [7:0]        data);
    logic [REGBUS-1:0] res;
    res = word;
    case (pos)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      default: res[7:0]   = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inst_rom_loader_rom_byte_packer.sv
// Assembles the loader byte stream into big-endian 32-bit words and flags
// when a complete word, or a zero-padded tail word on done, is ready to store.
module rom_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              done_i,
  output logic [REGBUS-1:0] word_o,
  output logic              word_valid_o,
  output logic              partial_o
);

  logic [1:0]        byte_cnt;
  logic [REGBUS-1:0] shift;
  logic [2:0]        cnt_after;
  logic [REGBUS-1:0] merged;

  // A byte arriving with done is merged before the word is emitted.
  always_comb begin
    merged       = byte_valid_i ? place_byte(shift, byte_cnt, byte_i) : shift;
    cnt_after    = {1'b0, byte_cnt} + {2'b00, byte_valid_i};
    word_o       = merged;
    word_valid_o = (cnt_after == 3'd4) || (done_i && (cnt_after != 3'd0));
    partial_o    = done_i && (cnt_after != 3'd0) && (cnt_after != 3'd4);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i || done_i) begin
      byte_cnt <= 2'd0;
      shift    <= ZEROWORD;
    end else if (byte_valid_i) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= (byte_cnt == 2'd3) ? ZEROWORD : merged;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory filled at boot from a byte stream; holds the core in reset
// until loading finishes, then answers fetches combinationally.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int MEM_AW   = INSTMEMNUMLOG2,
  parameter int RST_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INSTADDRBUS-1:0] rom_addr_i,
  output logic [REGBUS-1:0]      rom_data_o,
  input  logic                   load_valid_i,
  input  logic [7:0]             load_byte_i,
  output logic                   load_ready_o,
  input  logic                   load_done_i,
  input  logic                   reload_i,
  output logic                   cpu_rst_o,
  output logic [MEM_AW:0]        words_loaded_o,
  output logic                   overflow_o
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int HW    = $clog2(RST_HOLD + 2);

  loader_state_e     state;
  logic [MEM_AW:0]   word_ptr;
  logic [HW-1:0]     hold_cnt;
  logic [REGBUS-1:0] mem [DEPTH];

  logic              in_load;
  logic              full;
  logic              byte_take;
  logic              pack_take;
  logic              done_take;
  logic              reload_take;
  logic              mem_we;
  logic [REGBUS-1:0] pack_word;
  logic              pack_valid;
  logic              pack_partial;

  assign in_load     = (state == LOAD_S);
  assign full        = word_ptr[MEM_AW];
  assign byte_take   = load_valid_i && load_ready_o && in_load;
  assign pack_take   = byte_take && !full;
  assign done_take   = load_done_i && in_load;
  assign reload_take = reload_i && !in_load;
  assign mem_we      = (pack_valid || pack_partial) && in_load && !full;

  rom_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (reload_take),
    .byte_valid_i (pack_take),
    .byte_i       (load_byte_i),
    .done_i       (done_take),
    .word_o       (pack_word),
    .word_valid_o (pack_valid),
    .partial_o    (pack_partial)
  );

  // Contents survive reset on purpose; word_ptr decides which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_ptr[MEM_AW-1:0]] <= pack_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD_S;
      cpu_rst_o    <= 1'b1;
      load_ready_o <= 1'b1;
      word_ptr     <= '0;
      hold_cnt     <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (byte_take && full) begin
        overflow_o <= 1'b1;
      end
      case (state)
        LOAD_S: begin
          if (mem_we) begin
            word_ptr <= word_ptr + 1'b1;
          end
          if (done_take) begin
            state        <= HOLD_S;
            load_ready_o <= 1'b0;
            hold_cnt     <= '0;
          end
        end
        HOLD_S: begin
          if (reload_take) begin
            state        <= LOAD_S;
            load_ready_o <= 1'b1;
            word_ptr     <= '0;
          end else if (hold_cnt == HW'(RST_HOLD)) begin
            state     <= RUN_S;
            cpu_rst_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN_S: begin
          if (reload_take) begin
            state        <= LOAD_S;
            cpu_rst_o    <= 1'b1;
            load_ready_o <= 1'b1;
            word_ptr     <= '0;
          end
        end
        default: begin
          state        <= LOAD_S;
          cpu_rst_o    <= 1'b1;
          load_ready_o <= 1'b1;
          word_ptr     <= '0;
        end
      endcase
    end
  end

  assign words_loaded_o = word_ptr;

  logic [INSTADDRBUS-1:0] word_addr;
  logic [MEM_AW-1:0]      idx;
  logic                   addr_in_rom;

  // Byte offset bits drop out in the shift; anything past the array is a NOP.
  always_comb begin
    word_addr   = rom_addr_i >> 2;
    idx         = word_addr[MEM_AW-1:0];
    addr_in_rom = ((word_addr >> MEM_AW) == '0) && ({1'b0, idx} < word_ptr);
    rom_data_o  = ZEROWORD;
    if ((state == RUN_S) && rom_ce_i && addr_in_rom) begin
      rom_data_o = mem[idx];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a 1024-word instance and a 4-word
// instance for the full/overflow path.
module tb_inst_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_ce, a_valid, a_done, a_reload;
  logic [31:0] a_addr, a_data;
  logic [7:0]  a_byte;
  logic        a_ready, a_cpu_rst, a_ovf;
  logic [10:0] a_wl;

  logic        b_rst, b_ce, b_valid, b_done, b_reload;
  logic [31:0] b_addr, b_data;
  logic [7:0]  b_byte;
  logic        b_ready, b_cpu_rst, b_ovf;
  logic [2:0]  b_wl;

  inst_rom_loader #(.MEM_AW(10), .RST_HOLD(2)) dut_a (
    .clk(clk), .rst(a_rst), .rom_ce_i(a_ce), .rom_addr_i(a_addr), .rom_data_o(a_data),
    .load_valid_i(a_valid), .load_byte_i(a_byte), .load_ready_o(a_ready),
    .load_done_i(a_done), .reload_i(a_reload), .cpu_rst_o(a_cpu_rst),
    .words_loaded_o(a_wl), .overflow_o(a_ovf)
  );

  inst_rom_loader #(.MEM_AW(2), .RST_HOLD(2)) dut_b (
    .clk(clk), .rst(b_rst), .rom_ce_i(b_ce), .rom_addr_i(b_addr), .rom_data_o(b_data),
    .load_valid_i(b_valid), .load_byte_i(b_byte), .load_ready_o(b_ready),
    .load_done_i(b_done), .reload_i(b_reload), .cpu_rst_o(b_cpu_rst),
    .words_loaded_o(b_wl), .overflow_o(b_ovf)
  );

  localparam int K_A_DATA = 0, K_A_WL = 1, K_A_CPURST = 2, K_A_READY = 3, K_A_OVF = 4;
  localparam int K_B_DATA = 5, K_B_WL = 6, K_B_OVF = 7, K_B_READY = 8;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] actualOf(input int kind);
    case (kind)
      K_A_DATA:   return a_data;
      K_A_WL:     return {21'd0, a_wl};
      K_A_CPURST: return {31'd0, a_cpu_rst};
      K_A_READY:  return {31'd0, a_ready};
      K_A_OVF:    return {31'd0, a_ovf};
      K_B_DATA:   return b_data;
      K_B_WL:     return {29'd0, b_wl};
      K_B_OVF:    return {31'd0, b_ovf};
      default:    return {31'd0, b_ready};
    endcase
  endfunction

  // Monitor drains every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      sb_entry_t e;
      logic [31:0] act;
      e   = sb_q.pop_front();
      act = actualOf(e.kind);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input bit valid, input logic [7:0] data,
                               input bit done, input bit reload);
    if (!sel) begin
      a_valid = valid; a_byte = data; a_done = done; a_reload = reload;
    end else begin
      b_valid = valid; b_byte = data; b_done = done; b_reload = reload;
    end
    @(posedge clk);
    #1;
    if (!sel) begin
      a_valid = 1'b0; a_done = 1'b0; a_reload = 1'b0;
    end else begin
      b_valid = 1'b0; b_done = 1'b0; b_reload = 1'b0;
    end
  endtask

  task automatic sendByte(input bit sel, input logic [7:0] data);
    applyStimulus(sel, 1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic sendDone(input bit sel);
    applyStimulus(sel, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic resetDut(input bit sel);
    if (!sel) a_rst = 1'b1; else b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (!sel) a_rst = 1'b0; else b_rst = 1'b0;
  endtask

  task automatic waitRun();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic fetchA(input bit ce, input logic [31:0] addr, input logic [31:0] exp,
                        input string name);
    a_ce = ce;
    a_addr = addr;
    checkOutput(K_A_DATA, exp, name);
    settle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_ce = 1'b0; a_addr = '0; a_valid = 1'b0; a_byte = '0; a_done = 1'b0; a_reload = 1'b0;
    b_rst = 1'b1; b_ce = 1'b0; b_addr = '0; b_valid = 1'b0; b_byte = '0; b_done = 1'b0; b_reload = 1'b0;
    #1;
    resetDut(1'b0);
    resetDut(1'b1);

    // Reset state
    checkOutput(K_A_CPURST, 32'd1, "reset_cpu_rst");
    checkOutput(K_A_READY,  32'd1, "reset_ready");
    checkOutput(K_A_WL,     32'd0, "reset_words");
    checkOutput(K_A_OVF,    32'd0, "reset_ovf");
    fetchA(1'b1, 32'h0, 32'h0, "reset_fetch_nop");

    // One full word, then the reset-release timing
    sendByte(0, 8'h34); sendByte(0, 8'h02); sendByte(0, 8'h00); sendByte(0, 8'h05);
    sendDone(0);
    checkOutput(K_A_WL,     32'd1, "t1_words");
    checkOutput(K_A_CPURST, 32'd1, "t1_cpu_rst_e0");
    checkOutput(K_A_READY,  32'd0, "t1_ready_hold");
    fetchA(1'b1, 32'h0, 32'h0, "t1_fetch_in_hold");
    repeat (2) @(posedge clk);
    #1;
    checkOutput(K_A_CPURST, 32'd1, "t1_cpu_rst_e2");
    settle();
    @(posedge clk);
    #1;
    checkOutput(K_A_CPURST, 32'd0, "t1_cpu_rst_e3");
    settle();
    fetchA(1'b1, 32'h0, 32'h34020005, "t1_fetch0");
    fetchA(1'b1, 32'h2, 32'h34020005, "t1_fetch_lsb_ignored");

    // load_done in RUN is ignored
    sendDone(0);
    checkOutput(K_A_WL,     32'd1, "run_done_words");
    checkOutput(K_A_CPURST, 32'd0, "run_done_cpu_rst");
    settle();

    // Six bytes: one full word plus a zero-padded tail
    resetDut(0);
    sendByte(0, 8'hAA); sendByte(0, 8'hBB); sendByte(0, 8'hCC); sendByte(0, 8'hDD);
    sendByte(0, 8'h11); sendByte(0, 8'h22);
    sendDone(0);
    waitRun();
    checkOutput(K_A_WL, 32'd2, "t2_words");
    fetchA(1'b1, 32'h0,    32'hAABBCCDD, "t2_fetch0");
    fetchA(1'b1, 32'h4,    32'h11220000, "t2_fetch4_partial");
    fetchA(1'b1, 32'h8,    32'h0,        "t2_fetch8_unloaded");
    fetchA(1'b0, 32'h4,    32'h0,        "t2_fetch4_ce0");
    fetchA(1'b1, 32'h1000, 32'h0,        "t2_fetch_high_addr");

    // Byte accepted in the same cycle as done
    resetDut(0);
    sendByte(0, 8'h01); sendByte(0, 8'h02); sendByte(0, 8'h03);
    applyStimulus(0, 1'b1, 8'h77, 1'b1, 1'b0);
    waitRun();
    checkOutput(K_A_WL, 32'd1, "t3_words");
    fetchA(1'b1, 32'h0, 32'h01020377, "t3_fetch0");
    fetchA(1'b1, 32'h4, 32'h0,        "t3_fetch4_nop");

    // Reload from RUN
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput(K_A_CPURST, 32'd1, "t5_cpu_rst");
    checkOutput(K_A_READY,  32'd1, "t5_ready");
    checkOutput(K_A_WL,     32'd0, "t5_words");
    fetchA(1'b1, 32'h0, 32'h0, "t5_fetch_after_reload");
    sendByte(0, 8'hDE); sendByte(0, 8'hAD); sendByte(0, 8'hBE); sendByte(0, 8'hEF);
    sendDone(0);
    waitRun();
    checkOutput(K_A_WL, 32'd1, "t5_reload_words");
    fetchA(1'b1, 32'h0, 32'hDEADBEEF, "t5_fetch_reloaded");

    // Reset mid-word discards the partial bytes
    resetDut(0);
    sendByte(0, 8'hFF); sendByte(0, 8'hEE);
    resetDut(0);
    sendByte(0, 8'h0A); sendByte(0, 8'h0B); sendByte(0, 8'h0C); sendByte(0, 8'h0D);
    sendDone(0);
    waitRun();
    checkOutput(K_A_WL, 32'd1, "t6_words");
    fetchA(1'b1, 32'h0, 32'h0A0B0C0D, "t6_fetch0");
    fetchA(1'b1, 32'h4, 32'h0,        "t6_fetch4_nop");

    // Small instance: fill, overflow, out-of-range fetch
    for (int i = 0; i < 16; i++) sendByte(1, 8'(i + 1));
    checkOutput(K_B_WL,    32'd4, "t4_words_full");
    checkOutput(K_B_OVF,   32'd0, "t4_no_ovf_yet");
    checkOutput(K_B_READY, 32'd1, "t4_ready_when_full");
    settle();
    for (int i = 16; i < 20; i++) sendByte(1, 8'(i + 1));
    checkOutput(K_B_WL,    32'd4, "t4_words_after_extra");
    checkOutput(K_B_OVF,   32'd1, "t4_ovf");
    settle();
    sendDone(1);
    waitRun();
    b_ce = 1'b1;
    b_addr = 32'h0;
    checkOutput(K_B_DATA, 32'h01020304, "t4_fetch0");
    settle();
    b_addr = 32'hC;
    checkOutput(K_B_DATA, 32'h0D0E0F10, "t4_fetchC");
    settle();
    b_addr = 32'h10;
    checkOutput(K_B_DATA, 32'h0, "t4_fetch10_range");
    settle();
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput(K_B_OVF, 32'd1, "t4_ovf_kept_reload");
    settle();
    resetDut(1);
    checkOutput(K_B_OVF, 32'd0, "t4_ovf_cleared_rst");
    settle();

    settle();
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
